// File: rtl/apb_ram_slave.sv
// rtl/apb_ram_slave.sv - APB slave RAM with byte strobes, wait states and slverr.
module apb_ram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter int PRIV_WRITE  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [2:0]              prot,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    slverr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    a_write;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH-1:0]   a_wdata;
  logic [NB-1:0]           a_strb;
  logic                    a_priv;
  logic [3:0]              cnt;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  logic                    setup, exec;
  logic                    misaligned, out_of_range, denied, err;
  logic [31:0]             word_idx;
  logic [IDX_W-1:0]        ram_idx;
  logic                    unused_prot;

  assign unused_prot = ^prot[2:1];

  // Decode works on the latched setup-phase attributes, not the live bus.
  always_comb begin
    word_idx     = 32'(a_addr >> LSB);
    ram_idx      = word_idx[IDX_W-1:0];
    misaligned   = (a_addr & ALIGN_MASK) != '0;
    out_of_range = word_idx >= 32'(DEPTH);
    denied       = a_write && (PRIV_WRITE != 0) && !a_priv;
    err          = misaligned || out_of_range || denied;
  end

  always_comb begin
    state_nxt = state;
    setup     = 1'b0;
    exec      = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !enable) begin
          setup     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_nxt = IDLE;
        end else if (!enable) begin
          setup = 1'b1;
        end else if (cnt == 4'd0) begin
          exec      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_write <= 1'b0;
      a_addr  <= '0;
      a_wdata <= '0;
      a_strb  <= '0;
      a_priv  <= 1'b0;
      cnt     <= 4'd0;
      ready   <= 1'b0;
      slverr  <= 1'b0;
      rdata   <= '0;
    end else begin
      if (setup) begin
        a_write <= write;
        a_addr  <= addr;
        a_wdata <= wdata;
        a_strb  <= strb;
        a_priv  <= prot[0];
        cnt     <= 4'(WAIT_STATES);
      end else if (state == ACCESS && sel && enable && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (exec) begin
        ready  <= 1'b1;
        slverr <= err;
        rdata  <= (err || a_write) ? '0 : ram[ram_idx];
      end else if (state == RESP) begin
        ready  <= 1'b0;
        slverr <= 1'b0;
        rdata  <= '0;
      end
    end
  end

  // Storage is deliberately not reset; only lanes with a strobe are written.
  always_ff @(posedge clk) begin
    if (exec && a_write && !err) begin
      for (int i = 0; i < NB; i++) begin
        if (a_strb[i]) ram[ram_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_ram_slave.sv
// tb/tb_apb_ram_slave.sv - self-checking bench for apb_ram_slave.
module tb_apb_ram_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel0 = 1'b0, sel1 = 1'b0, enable = 1'b0, write = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  strb = '0;
  logic [2:0]  prot = '0;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, slverr0, slverr1;

  int checks = 0;
  int errors = 0;
  bit [31:0] mem [2][64];

  always #5 clk = ~clk;

  apb_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(64), .WAIT_STATES(0), .PRIV_WRITE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .sel(sel0), .enable(enable), .write(write), .addr(addr),
    .wdata(wdata), .strb(strb), .prot(prot), .rdata(rdata0), .ready(ready0), .slverr(slverr0));

  apb_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(64), .WAIT_STATES(3), .PRIV_WRITE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .sel(sel1), .enable(enable), .write(write), .addr(addr),
    .wdata(wdata), .strb(strb), .prot(prot), .rdata(rdata1), .ready(ready1), .slverr(slverr1));

  function automatic logic get_ready(input int i);
    return (i == 0) ? ready0 : ready1;
  endfunction
  function automatic logic get_slverr(input int i);
    return (i == 0) ? slverr0 : slverr1;
  endfunction
  function automatic logic [31:0] get_rdata(input int i);
    return (i == 0) ? rdata0 : rdata1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: word-addressed array updated byte by byte from the access rules.
  task automatic model(input int inst, input bit w, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p, output bit e_err, output logic [31:0] e_rd);
    int wi;
    wi = int'(a) / 4;
    e_err = (int'(a) % 4 != 0) || (wi >= 64) || (w && inst == 1 && p[0] == 1'b0);
    e_rd = 32'h0;
    if (!e_err) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem[inst][wi][8*b +: 8] = d[8*b +: 8];
      end else begin
        e_rd = mem[inst][wi];
      end
    end
  endtask

  task automatic xfer(input int inst, input bit w, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, output logic [31:0] rd, output logic er);
    int lat;
    if (inst == 0) sel0 = 1'b1; else sel1 = 1'b1;
    enable = 1'b0; write = w; addr = a; wdata = d; strb = s; prot = p;
    @(posedge clk); #1;
    enable = 1'b1;
    lat = 0;
    while (get_ready(inst) !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), (inst == 0) ? 32'd1 : 32'd4);
    rd = get_rdata(inst);
    er = get_slverr(inst);
    @(posedge clk); #1;
    sel0 = 1'b0; sel1 = 1'b0; enable = 1'b0;
    check("ready_slverr_after_resp", {30'h0, get_ready(inst), get_slverr(inst)}, 32'h0);
    check("rdata_after_resp", get_rdata(inst), 32'h0);
  endtask

  task automatic run(input int inst, input bit w, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [2:0] p, input string tag);
    bit e_err;
    logic [31:0] e_rd, rd;
    logic er;
    model(inst, w, a, d, s, p, e_err, e_rd);
    xfer(inst, w, a, d, s, p, rd, er);
    check({tag, "_slverr"}, {31'h0, er}, {31'h0, e_err});
    check({tag, "_rdata"}, rd, e_rd);
  endtask

  typedef struct {
    int         inst;
    bit         w;
    logic [9:0] a;
    logic [31:0] d;
    logic [3:0] s;
    logic [2:0] p;
    bit         e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [31:0] rd;
    logic er;
    bit e_err;
    logic [31:0] e_rd;
    bit saw;

    tbl[0]  = '{0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b0, 10'h010, 32'h0,        4'hF, 3'b000, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{0, 1'b1, 10'h020, 32'h11223344, 4'hF, 3'b000, 1'b0, 32'h0};
    tbl[3]  = '{0, 1'b1, 10'h020, 32'hAABBCCDD, 4'h5, 3'b000, 1'b0, 32'h0};
    tbl[4]  = '{0, 1'b0, 10'h020, 32'h0,        4'h0, 3'b000, 1'b0, 32'h11BB33DD};
    tbl[5]  = '{0, 1'b0, 10'h100, 32'h0,        4'hF, 3'b000, 1'b1, 32'h0};
    tbl[6]  = '{0, 1'b1, 10'h012, 32'h55555555, 4'hF, 3'b000, 1'b1, 32'h0};
    tbl[7]  = '{0, 1'b0, 10'h010, 32'h0,        4'hF, 3'b000, 1'b0, 32'hDEADBEEF};
    tbl[8]  = '{0, 1'b1, 10'h014, 32'hFFFFFFFF, 4'h0, 3'b000, 1'b0, 32'h0};
    tbl[9]  = '{0, 1'b0, 10'h014, 32'h0,        4'hF, 3'b000, 1'b0, 32'hA5000005};
    tbl[10] = '{1, 1'b1, 10'h030, 32'hCAFEF00D, 4'hF, 3'b001, 1'b0, 32'h0};
    tbl[11] = '{1, 1'b1, 10'h030, 32'h12345678, 4'hF, 3'b000, 1'b1, 32'h0};
    tbl[12] = '{1, 1'b0, 10'h030, 32'h0,        4'hF, 3'b000, 1'b0, 32'hCAFEF00D};
    tbl[13] = '{1, 1'b1, 10'h030, 32'h12345678, 4'hF, 3'b001, 1'b0, 32'h0};
    tbl[14] = '{1, 1'b0, 10'h3FC, 32'h0,        4'hF, 3'b001, 1'b1, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_u0", {ready0, slverr0, rdata0[29:0]}, 32'h0);
    check("reset_u1", {ready1, slverr1, rdata1[29:0]}, 32'h0);
    check("reset_rdata_hi", {30'h0, rdata0[31:30] | rdata1[31:30]}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int inst = 0; inst < 2; inst++)
      for (int i = 0; i < 64; i++)
        run(inst, 1'b1, 10'(i * 4), 32'hA500_0000 + 32'(inst << 16) + 32'(i), 4'hF, 3'b001, "init");

    for (int k = 0; k < 15; k++) begin
      model(tbl[k].inst, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].s, tbl[k].p, e_err, e_rd);
      xfer(tbl[k].inst, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].s, tbl[k].p, rd, er);
      check($sformatf("vec%0d_slverr", k), {31'h0, er}, {31'h0, tbl[k].e_err});
      check($sformatf("vec%0d_rdata", k), rd, tbl[k].e_rd);
    end

    // Abort a waited write mid-access: no completion, memory untouched.
    sel1 = 1'b1; enable = 1'b0; write = 1'b1; addr = 10'h004; wdata = 32'hBAD0BAD0; strb = 4'hF; prot = 3'b001;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sel1 = 1'b0; enable = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      saw |= ready1;
    end
    check("abort_no_ready", {31'h0, saw}, 32'h0);
    run(1, 1'b0, 10'h004, 32'h0, 4'hF, 3'b001, "abort_readback");

    // Reset while the response is on the bus.
    sel0 = 1'b1; enable = 1'b0; write = 1'b0; addr = 10'h010; strb = 4'hF; prot = 3'b000;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    check("resp_ready", {31'h0, ready0}, 32'h1);
    check("resp_rdata", rdata0, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ready_slverr", {30'h0, ready0, slverr0}, 32'h0);
    check("async_reset_rdata", rdata0, 32'h0);
    sel0 = 1'b0; enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 1'b0, 10'h010, 32'h0, 4'hF, 3'b000, "post_reset_read");

    // Reset while a write is still waiting: it must never land.
    sel1 = 1'b1; enable = 1'b0; write = 1'b1; addr = 10'h008; wdata = 32'h77777777; strb = 4'hF; prot = 3'b001;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset_in_access_ready", {31'h0, ready1}, 32'h0);
    sel1 = 1'b0; enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(1, 1'b0, 10'h008, 32'h0, 4'hF, 3'b001, "reset_write_dropped");

    for (int n = 0; n < 300; n++) begin
      int inst, r;
      logic [9:0] a;
      inst = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 10'($urandom_range(0, 15) * 4);
      else if (r == 7) a = 10'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             a = 10'($urandom_range(64, 255) * 4);
      run(inst, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          3'($urandom_range(0, 7)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
